// File: rtl/stall_scoreboard_unit_pkg.sv
// Shared types and helpers for the decode stall scoreboard.
// Holds the multi-cycle unit state encoding and the width function.
package stall_scoreboard_unit_pkg;

  typedef enum logic [1:0] {
    UNIT_IDLE = 2'd0,
    UNIT_MULT = 2'd1,
    UNIT_DIV  = 2'd2
  } unit_state_e;

  function automatic int clog2_w(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/multicycle_unit_tracker.sv
// Occupancy tracker for the shared multiplier/divider.
// Frees the unit in its last busy cycle so back-to-back issue works.
module multicycle_unit_tracker
  import stall_scoreboard_unit_pkg::*;
#(
  parameter int MULT_LATENCY = 4,
  parameter int DIV_LATENCY  = 33,
  parameter int CNT_W        = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic start_mult_i,
  input  logic start_div_i,
  output logic unit_busy_o,
  output logic free_o
);

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LATENCY);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  unit_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= UNIT_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (start_mult_i) begin
      state_q <= UNIT_MULT;
      cnt_q   <= MULT_CNT;
      busy_q  <= 1'b1;
    end else if (start_div_i) begin
      state_q <= UNIT_DIV;
      cnt_q   <= DIV_CNT;
      busy_q  <= 1'b1;
    end else if (state_q != UNIT_IDLE) begin
      if (cnt_q <= CNT_ONE) begin
        state_q <= UNIT_IDLE;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        cnt_q   <= cnt_q - CNT_ONE;
      end
    end
  end

  assign unit_busy_o = busy_q;
  assign free_o      = (state_q == UNIT_IDLE) || (cnt_q == CNT_ONE);

endmodule

// File: rtl/stall_scoreboard_unit.sv
// Decode-stage register scoreboard with structural stall for mul/div.
// Produces the issue strobe and the fetch/decode freeze signal.
module stall_scoreboard_unit
  import stall_scoreboard_unit_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int MULT_LATENCY = 4,
  parameter int DIV_LATENCY  = 33,
  parameter int STALL_EXTEND = 1,
  parameter int WB_BYPASS    = 1,
  parameter int REG_W        = clog2_w(NUM_REGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             valid_decode,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             rs1_used,
  input  logic             rs2_used,
  input  logic [REG_W-1:0] rd_decode,
  input  logic             regwrite_decode,
  input  logic             is_mult,
  input  logic             is_div,
  input  logic             regwrite_writeback,
  input  logic [REG_W-1:0] rd_writeback,
  input  logic             flush,
  output logic             stall_needed,
  output logic             issue,
  output logic             unit_busy
);

  localparam int MAX_LAT = (MULT_LATENCY > DIV_LATENCY) ?
                           MULT_LATENCY : DIV_LATENCY;
  localparam int CNT_W   = clog2_w(MAX_LAT + 1);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                hazard_q;
  logic                wb_hit1, wb_hit2;
  logic                src1_busy, src2_busy;
  logic                data_haz, struct_haz, hazard;
  logic                unit_free;

  // Write-through regfile: a retiring write satisfies a same-cycle read.
  assign wb_hit1 = (WB_BYPASS != 0) && regwrite_writeback &&
                   (rd_writeback == rs1);
  assign wb_hit2 = (WB_BYPASS != 0) && regwrite_writeback &&
                   (rd_writeback == rs2);

  assign src1_busy = busy_q[rs1] && !wb_hit1;
  assign src2_busy = busy_q[rs2] && !wb_hit2;

  assign data_haz   = valid_decode &&
                      ((rs1_used && src1_busy) ||
                       (rs2_used && src2_busy));
  assign struct_haz = valid_decode && (is_mult || is_div) && !unit_free;
  assign hazard     = data_haz || struct_haz;

  assign issue = reset && valid_decode && !hazard && !flush;

  assign stall_needed = reset &&
                        (hazard || ((STALL_EXTEND != 0) && hazard_q));

  always_comb begin
    busy_d = busy_q;
    if (regwrite_writeback) busy_d[rd_writeback] = 1'b0;
    if (issue && regwrite_decode && (rd_decode != '0))
      busy_d[rd_decode] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q   <= '0;
      hazard_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      hazard_q <= hazard;
    end
  end

  multicycle_unit_tracker #(
    .MULT_LATENCY (MULT_LATENCY),
    .DIV_LATENCY  (DIV_LATENCY),
    .CNT_W        (CNT_W)
  ) u_tracker (
    .clock        (clock),
    .reset        (reset),
    .start_mult_i (issue && is_mult),
    .start_div_i  (issue && is_div),
    .unit_busy_o  (unit_busy),
    .free_o       (unit_free)
  );

endmodule

// File: doc/stall_scoreboard_unit.md
STALL_SCOREBOARD_UNIT -- requirements
Module: stall_scoreboard_unit

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, number of architectural registers; REG_W = clog2(NUM_REGS).
REQ-002 SHALL have parameter MULT_LATENCY, default 4, cycles the multiplier occupies after issue (range 1..15).
REQ-003 SHALL have parameter DIV_LATENCY, default 33, cycles the divider occupies after issue (range 1..63).
REQ-004 SHALL have parameter STALL_EXTEND, default 1, extra cycles stall_needed is held after a hazard clears (0 or 1).
REQ-005 SHALL have parameter WB_BYPASS, default 1; 1 = register file writes through, so a same-cycle writeback satisfies a read.
REQ-006 clock  input  1  single clock, all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-low; all state cleared while low.
REQ-008 valid_decode  input  1  decode holds a real instruction.
REQ-009 rs1, rs2  input  REG_W each  decode source registers; rs1_used, rs2_used  input  1 each  source actually read.
REQ-010 rd_decode  input  REG_W  decode destination; regwrite_decode  input  1  decode instruction writes rd.
REQ-011 is_mult, is_div  input  1 each  decode instruction uses the multiplier / divider (mutually exclusive).
REQ-012 regwrite_writeback  input  1; rd_writeback  input  REG_W  retiring write that releases a register.
REQ-013 flush  input  1  cancels the decode instruction this cycle.
REQ-014 stall_needed  output  1  freeze fetch/decode.
REQ-015 issue  output  1  decode instruction accepted this cycle.
REQ-016 unit_busy  output  1  multi-cycle unit occupied (FSM not IDLE).

Function
REQ-017 Scoreboard SHALL hold one busy bit per register; register 0 bit SHALL never be set.
REQ-018 Data hazard = valid_decode & ((rs1_used & busy[rs1]) | (rs2_used & busy[rs2])); with WB_BYPASS=1 a source equal to rd_writeback with regwrite_writeback high SHALL not count as busy that cycle.
REQ-019 Structural hazard = valid_decode & (is_mult | is_div) & FSM not IDLE; the FSM SHALL count as IDLE in the cycle its counter reaches 1 (back-to-back issue allowed).
REQ-020 hazard = data hazard | structural hazard; issue = valid_decode & ~hazard & ~flush.
REQ-021 On issue with regwrite_decode and rd_decode != 0, busy[rd_decode] SHALL be set at the next edge.
REQ-022 On regwrite_writeback, busy[rd_writeback] SHALL be cleared at the next edge; same-register set and clear in one cycle SHALL leave the bit set.
REQ-023 FSM states IDLE, MULT, DIV; IDLE->MULT on issue & is_mult, counter loaded MULT_LATENCY; IDLE->DIV on issue & is_div, counter loaded DIV_LATENCY.
REQ-024 MULT/DIV SHALL decrement the counter each cycle and return to IDLE when it reaches 1, unless a new mult/div issues that cycle, which reloads the counter and enters the matching state.
REQ-025 Counter width SHALL be clog2(max(MULT_LATENCY,DIV_LATENCY)+1); it SHALL not underflow.
REQ-026 stall_needed = hazard | (STALL_EXTEND & hazard_q), where hazard_q is hazard registered one cycle; with STALL_EXTEND=0 the stall is purely combinational.
REQ-027 flush SHALL suppress issue and scoreboard set only; in-flight busy bits and the FSM SHALL be unaffected.
REQ-028 Inputs with valid_decode low SHALL produce no hazard, no issue, no state change except writeback clears and FSM counting.

Reset
REQ-029 While reset low: all busy bits 0, FSM IDLE, counter 0, hazard_q 0; hence stall_needed 0, issue 0, unit_busy 0.
REQ-030 Reset asserted mid-operation SHALL abort any MULT/DIV count immediately and asynchronously.

Structure
REQ-031 Shared package SHALL hold the FSM state encoding (IDLE, MULT, DIV) and the clog2 width helper.
REQ-032 One sub-module, multicycle_unit_tracker (FSM plus counter), SHALL be instantiated; the scoreboard stays in the top module.

Verification
REQ-033 Issue rd=5 regwrite; next cycle rs1=5 used -> stall_needed 1, issue 0; writeback rd=5 -> stall drops that cycle (WB_BYPASS=1), stays 1 extra cycle with STALL_EXTEND=1.
REQ-034 Issue rd=0 regwrite, then rs2=0 used -> no stall, busy[0] remains 0.
REQ-035 Issue is_mult (MULT_LATENCY=4), then is_mult on next cycle -> stalled 3 cycles, issues in the 4th cycle; unit_busy continuous.
REQ-036 Same cycle: writeback rd=7 and issue rd=7 -> busy[7]=1 afterwards; dependent read rs1=7 stalls.
REQ-037 Issue is_div (DIV_LATENCY=33), assert reset at cycle 10 -> unit_busy 0 and stall_needed 0 immediately; following is_div issues without stall.
REQ-038 Hazard-free instruction with flush=1 and rd=9 -> issue 0, busy[9] stays 0.
